operand_fetch: RTL
==================

# operand_fetch

Operand-fetch and writeback sequencer between the instruction decoder and the single-port 16×32 register bank. It serialises rs1/rs2 reads and rd writebacks onto the bank's one `select`/`write` port and presents both operands plus rd to the execute stage. The valid/ready handshake runs on both sides. Writeback always wins the port, and x0 operands never consume a bank cycle.

## Interface
- `XLEN`, 32, datapath width.
- `REG_IDX_W`, 4, register index width (16 registers).
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset; single clock domain.
- `id_valid`  in  1  decoder offers an instruction.
- `id_ready`  out  1  block accepts the instruction.
- `id_rs1`, `id_rs2`, `id_rd`  in  REG_IDX_W each  source and destination indices.
- `ex_valid`  out  1  operands valid.
- `ex_ready`  in  1  execute stage consumes the operands.
- `ex_op_a`, `ex_op_b`  out  XLEN each  rs1 and rs2 values.
- `ex_rd`  out  REG_IDX_W  destination index, passed through.
- `wb_valid`  in  1  writeback request; always accepted in the cycle it is presented.
- `wb_rd`  in  REG_IDX_W  writeback index.
- `wb_data`  in  XLEN  writeback data.
- `rb_select`  out  REG_IDX_W  to bank `select`.
- `rb_write`  out  1  to bank `write`.
- `rb_data_in`  out  XLEN  to bank `dataIn`.
- `rb_data_out`  in  XLEN  from bank `dataOut`. The bank read is combinational on `select`.

## Operation
- **States:** IDLE, READ_A, READ_B, VALID.
- **Accept:** `id_ready` = (IDLE) or (VALID and `ex_ready`).
  - On `id_valid` and `id_ready`, latch rs1, rs2 and rd.
  - Next state: READ_A if rs1≠0, else READ_B if rs2≠0, else VALID.
  - A zero index loads 0 into its operand register at accept.
- **Port grant:** `wb_port` = `wb_valid` and `wb_rd`≠0.
  - When `wb_port`: `rb_select`=`wb_rd`, `rb_write`=1, `rb_data_in`=`wb_data`.
  - A writeback to x0 is dropped and leaves the port free.
- **READ_A:** if the port is free, `rb_select`=rs1, and `ex_op_a` captures `rb_data_out` at the edge.
  - Next state: READ_B if rs2≠0, else VALID.
  - If the port is taken, stay in READ_A (stall).
- **READ_B:** same as READ_A for rs2 and `ex_op_b`; next state VALID.
- **VALID:** `ex_valid`=1. Operands and `ex_rd` are held stable until `ex_ready`.
  - On `ex_ready` without a new accept, go to IDLE.
  - With a new accept, branch as in **Accept** (back-to-back).
- **Port idle:** `rb_select`=0, `rb_write`=0, `rb_data_in`=`wb_data`.
- **RAW ordering:** an operand holds the bank value at its capture edge. Read-after-write ordering against older in-flight instructions is the issuer's responsibility.

## Timing
- **Reset values:** state IDLE; `ex_valid`=0; `ex_op_a`/`ex_op_b`/`ex_rd`=0.
  - `id_ready`=1 in the first cycle after reset.
  - `rb_write` is forced to 0 while `reset` is high.
- **Latency:** `ex_valid` rises k edges after the accept edge, where k = (number of nonzero sources) + (number of stall cycles). Both-zero gives k=0, i.e. valid in the cycle after accept.
- **Writeback timing:** a writeback lands at the edge ending the cycle it is presented in. A read in the following cycle returns the new value.
- **Reset mid-operation:** latched indices and operands are discarded, the state returns to IDLE, and no bank write occurs in the reset cycle.
- **Simultaneous events:** `wb_valid` in VALID or IDLE never stalls anything. Accept and writeback can occur in the same cycle.

## Configuration
- **`OPERAND_FETCH_BYPASS_EN` defined:** in READ_A/READ_B with `wb_port` and `wb_rd` equal to the source being read, the operand captures `wb_data` and the state advances. There is no stall.
- **Not defined:** any port conflict stalls one cycle per writeback cycle.

## Structure
- Shared package `neko_cpu_pkg`:
  - `XLEN`, `REG_IDX_W`, `NUM_REGS`=16;
  - `opf_state_t` enum {IDLE, READ_A, READ_B, VALID}.
- One sub-module, `opf_port_mux`: combinational grant and drive of `rb_select`/`rb_write`/`rb_data_in`, plus the stall/bypass decision.

## Test plan
- **Basic fetch:** write x3=0xDEADBEEF and x5=0x12345678 via wb, then issue rs1=3, rs2=5, rd=7 → `ex_valid` 2 edges after accept, `ex_op_a`=0xDEADBEEF, `ex_op_b`=0x12345678, `ex_rd`=7.
- **Both sources x0:** rs1=0, rs2=0 → `ex_valid` the cycle after accept, operands 0, `rb_select` stays 0 with no reads.
- **Stall on writeback:** `wb_valid` (x9=0x55) held for 2 cycles during READ_A of rs1=3 → READ_A lasts 3 cycles, x9 is written, `ex_op_a` is correct.
- **Bypass:** with `OPERAND_FETCH_BYPASS_EN`, wb x3=0xCAFEF00D during READ_A of rs1=3 → `ex_op_a`=0xCAFEF00D with no stall. Without the macro, 1 stall cycle, then the same value.
- **Backpressure:** `ex_ready` low for 3 cycles → outputs stable and `id_ready`=0. Then `ex_ready` and `id_valid` together → back-to-back accept.
- **Reset and x0 writeback:** `reset` pulsed in READ_B → next cycle IDLE, `ex_valid`=0. A wb to x0 → `rb_write`=0 and the concurrent read is not stalled.

Source files
------------

// File: rtl/neko_cpu_pkg.sv
// Shared definitions for the neko CPU front end.
//   XLEN      : datapath width
//   REG_IDX_W : register index width
//   NUM_REGS  : number of architectural registers in the bank
//   opf_state_t    : operand-fetch sequencer states
//   opf_first_state: state entered after an accept. It depends on which
//                    source indices are nonzero, because x0 reads skip the bank.
package neko_cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 4;
  localparam int NUM_REGS  = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ_A = 2'd1,
    READ_B = 2'd2,
    VALID  = 2'd3
  } opf_state_t;

  // x0 always reads as zero, so a zero index skips its bank read entirely.
  function automatic opf_state_t opf_first_state(input logic [REG_IDX_W-1:0] rs1,
                                                 input logic [REG_IDX_W-1:0] rs2);
    if (rs1 != '0)      return READ_A;
    else if (rs2 != '0) return READ_B;
    else                return VALID;
  endfunction

endpackage

// File: rtl/opf_port_mux.sv
// Single-port register bank arbitration for the operand-fetch sequencer.
// A writeback always wins the port. A read gets the port only when no writeback
// holds it.
// Optional feature (macro OPERAND_FETCH_BYPASS_EN): a writeback to the exact
// register being read forwards its data into the operand, so the read does not stall.
// Ports:
//   reset        : forces rb_write low while asserted
//   state        : current sequencer state
//   rs1, rs2     : latched source indices
//   wb_valid/wb_rd/wb_data : writeback request
//   rb_data_out  : combinational bank read data
//   rb_select/rb_write/rb_data_in : bank port drive
//   capture      : the operand register for the current read state loads this cycle
//   capture_data : value that operand register loads
module opf_port_mux
  import neko_cpu_pkg::*;
(
  input  logic                 reset,
  input  opf_state_t           state,
  input  logic [REG_IDX_W-1:0] rs1,
  input  logic [REG_IDX_W-1:0] rs2,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [XLEN-1:0]      rb_data_out,
  output logic [REG_IDX_W-1:0] rb_select,
  output logic                 rb_write,
  output logic [XLEN-1:0]      rb_data_in,
  output logic                 capture,
  output logic [XLEN-1:0]      capture_data
);

  logic                 wb_port;
  logic                 reading;
  logic [REG_IDX_W-1:0] src;

  // The writeback owns the port whenever it targets a real register. A write to
  // x0 is dropped, so the port stays free for a pending read.
  always_comb begin
    wb_port      = wb_valid && (wb_rd != '0);
    reading      = (state == READ_A) || (state == READ_B);
    src          = (state == READ_B) ? rs2 : rs1;
    rb_select    = '0;
    rb_write     = 1'b0;
    rb_data_in   = wb_data;
    capture      = 1'b0;
    capture_data = rb_data_out;
    if (wb_port) begin
      rb_select = wb_rd;
      rb_write  = !reset;
    end else if (reading) begin
      rb_select = src;
      capture   = 1'b1;
    end
`ifdef OPERAND_FETCH_BYPASS_EN
    if (reading && wb_port && (wb_rd == src)) begin
      capture      = 1'b1;
      capture_data = wb_data;
    end
`endif
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand-fetch and writeback sequencer. It sits between the decoder and the
// single-port 16x32 register bank. Reads of rs1 and rs2 are serialised onto the
// bank port. Writebacks take priority on that port. Both operands and rd go to
// the execute stage with a valid/ready handshake.
// Optional feature (macro OPERAND_FETCH_BYPASS_EN): writeback-to-operand forwarding
// during a read, implemented in opf_port_mux.
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   id_valid/id_ready, id_rs1/id_rs2/id_rd : decoder handshake and indices
//   ex_valid/ex_ready, ex_op_a/ex_op_b/ex_rd : execute handshake and operands
//   wb_valid/wb_rd/wb_data : writeback request, accepted in the cycle it is presented
//   rb_select/rb_write/rb_data_in/rb_data_out : register bank port
module operand_fetch
  import neko_cpu_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  output logic                 id_ready,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic [REG_IDX_W-1:0] id_rd,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [XLEN-1:0]      ex_op_a,
  output logic [XLEN-1:0]      ex_op_b,
  output logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 wb_valid,
  input  logic [REG_IDX_W-1:0] wb_rd,
  input  logic [XLEN-1:0]      wb_data,
  output logic [REG_IDX_W-1:0] rb_select,
  output logic                 rb_write,
  output logic [XLEN-1:0]      rb_data_in,
  input  logic [XLEN-1:0]      rb_data_out
);

  opf_state_t           state;
  logic [REG_IDX_W-1:0] rs1_q;
  logic [REG_IDX_W-1:0] rs2_q;
  logic                 accept;
  logic                 capture;
  logic [XLEN-1:0]      capture_data;

  opf_port_mux u_port_mux (
    .reset        (reset),
    .state        (state),
    .rs1          (rs1_q),
    .rs2          (rs2_q),
    .wb_valid     (wb_valid),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .rb_data_out  (rb_data_out),
    .rb_select    (rb_select),
    .rb_write     (rb_write),
    .rb_data_in   (rb_data_in),
    .capture      (capture),
    .capture_data (capture_data)
  );

  // A new instruction is taken when idle. It is also taken in the same cycle the
  // execute stage consumes the current one, which allows back-to-back issue.
  always_comb begin
    ex_valid = (state == VALID);
    id_ready = (state == IDLE) || ((state == VALID) && ex_ready);
    accept   = id_valid && id_ready;
  end

  // Sequencer state machine. A zero source index preloads 0 into its operand at
  // accept and is never read from the bank. A read state holds until the port
  // mux grants a capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      ex_rd   <= '0;
      ex_op_a <= '0;
      ex_op_b <= '0;
    end else if (accept) begin
      rs1_q <= id_rs1;
      rs2_q <= id_rs2;
      ex_rd <= id_rd;
      if (id_rs1 == '0) ex_op_a <= '0;
      if (id_rs2 == '0) ex_op_b <= '0;
      state <= opf_first_state(id_rs1, id_rs2);
    end else begin
      case (state)
        READ_A: begin
          if (capture) begin
            ex_op_a <= capture_data;
            state   <= (rs2_q != '0) ? READ_B : VALID;
          end
        end
        READ_B: begin
          if (capture) begin
            ex_op_b <= capture_data;
            state   <= VALID;
          end
        end
        VALID: begin
          if (ex_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
